// File: rtl/wishbone_arbiter_if.sv
// Wishbone classic bus bundle shared by both master ports and the slave port of the arbiter.
// The master modport is the side that issues cycles; the slave modport answers them.
interface wishbone_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;
  logic [3:0]            sel;
  logic                  stb;
  logic                  cyc;
  logic                  ack;

  modport master (
    output addr, wdata, we, sel, stb, cyc,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, we, sel, stb, cyc,
    output rdata, ack
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter: registered round-robin grant, bus lock for the whole CYC,
// and a per-transfer ACK watchdog that errors out a master whose slave stops answering.
module wishbone_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  wishbone_arbiter_if.slave    m0,
  wishbone_arbiter_if.slave    m1,
  wishbone_arbiter_if.master   s,
  output logic                 o_M0_ERR,
  output logic                 o_M1_ERR,
  output logic [1:0]           o_GNT
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e               state, state_next;
  logic                 last_gnt;
  logic [TIMER_W-1:0]   timer;
  logic [1:0]           err_block;

  logic req0, req1;
  logic timeout0, timeout1;
  logic release0, release1;
  logic cur_stb;

  // A master that was errored out must drop CYC once before it may compete again.
  assign req0 = m0.cyc && !err_block[0];
  assign req1 = m1.cyc && !err_block[1];

  assign timeout0 = (state == GNT0) && m0.cyc && m0.stb && !s.ack && (timer == TIMER_LAST);
  assign timeout1 = (state == GNT1) && m1.cyc && m1.stb && !s.ack && (timer == TIMER_LAST);
  assign release0 = (state == GNT0) && !m0.cyc;
  assign release1 = (state == GNT1) && !m1.cyc;
  assign cur_stb  = ((state == GNT0) && m0.stb) || ((state == GNT1) && m1.stb);

  assign o_M0_ERR = timeout0;
  assign o_M1_ERR = timeout1;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      timer     <= '0;
      err_block <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;

      if (release0 || timeout0)      last_gnt <= 1'b0;
      else if (release1 || timeout1) last_gnt <= 1'b1;

      if ((state_next != state) || (state == IDLE) || s.ack) timer <= '0;
      else if (cur_stb && (timer != TIMER_MAX))              timer <= timer + TIMER_W'(1);

      err_block[0] <= m0.cyc && (err_block[0] || timeout0);
      err_block[1] <= m1.cyc && (err_block[1] || timeout1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_next = last_gnt ? GNT0 : GNT1;
        else if (req0)    state_next = GNT0;
        else if (req1)    state_next = GNT1;
      end
      GNT0: begin
        if (!m0.cyc)       state_next = req1 ? GNT1 : IDLE;
        else if (timeout0) state_next = IDLE;
      end
      GNT1: begin
        if (!m1.cyc)       state_next = req0 ? GNT0 : IDLE;
        else if (timeout1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    s.addr   = {ADDR_WIDTH{1'b0}};
    s.wdata  = {DATA_WIDTH{1'b0}};
    s.we     = 1'b0;
    s.sel    = 4'h0;
    s.stb    = 1'b0;
    s.cyc    = 1'b0;
    m0.rdata = {DATA_WIDTH{1'b0}};
    m0.ack   = 1'b0;
    m1.rdata = {DATA_WIDTH{1'b0}};
    m1.ack   = 1'b0;
    o_GNT    = 2'b00;
    unique case (state)
      GNT0: begin
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.cyc    = m0.cyc && !timeout0;
        s.stb    = m0.stb && !timeout0;
        m0.rdata = s.rdata;
        m0.ack   = s.ack;
        o_GNT    = 2'b01;
      end
      GNT1: begin
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.cyc    = m1.cyc && !timeout1;
        s.stb    = m1.stb && !timeout1;
        m1.rdata = s.rdata;
        m1.ack   = s.ack;
        o_GNT    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against an owner/turn/wait-count model of the arbitration rules.
module tb_wishbone_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b0;
  logic       o_M0_ERR, o_M1_ERR;
  logic [1:0] o_GNT;

  wishbone_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  wishbone_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();
  wishbone_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_bus ();

  wishbone_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .s        (s_bus),
    .o_M0_ERR (o_M0_ERR),
    .o_M1_ERR (o_M1_ERR),
    .o_GNT    (o_GNT)
  );

  always #5 i_CLK = ~i_CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), whose turn was last, how long the
  // owner has strobed without an answer, and which masters are banned until CYC drops.
  int owner    = -1;
  int last     = 1;
  int wait_cnt = 0;
  bit blk [2];

  function automatic logic cyc_of(input int m);
    return (m == 0) ? m0_bus.cyc : m1_bus.cyc;
  endfunction
  function automatic logic stb_of(input int m);
    return (m == 0) ? m0_bus.stb : m1_bus.stb;
  endfunction
  function automatic logic we_of(input int m);
    return (m == 0) ? m0_bus.we : m1_bus.we;
  endfunction
  function automatic logic [3:0] sel_of(input int m);
    return (m == 0) ? m0_bus.sel : m1_bus.sel;
  endfunction
  function automatic logic [AW-1:0] addr_of(input int m);
    return (m == 0) ? m0_bus.addr : m1_bus.addr;
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int m);
    return (m == 0) ? m0_bus.wdata : m1_bus.wdata;
  endfunction

  always @(negedge i_CLK) begin : scoreboard
    logic          to;
    logic [1:0]    e_gnt;
    logic [6:0]    e_ctrl;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            r0, r1;
    bit            nblk0, nblk1;

    if (!i_RST) begin
      owner    = -1;
      last     = 1;
      wait_cnt = 0;
      blk[0]   = 1'b0;
      blk[1]   = 1'b0;
    end

    to      = (owner >= 0) && cyc_of(owner) && stb_of(owner) && !s_bus.ack && (wait_cnt == TO - 1);
    e_gnt   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_ctrl  = '0;
    e_addr  = '0;
    e_wdata = '0;
    if (owner >= 0) begin
      e_ctrl  = {cyc_of(owner) && !to, stb_of(owner) && !to, we_of(owner), sel_of(owner)};
      e_addr  = addr_of(owner);
      e_wdata = wdata_of(owner);
    end

    check("gnt", o_GNT, e_gnt);
    check("s_ctrl", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel}, e_ctrl);
    check("s_addr", s_bus.addr, e_addr);
    check("s_wdata", s_bus.wdata, e_wdata);
    check("m0_ack_err", {m0_bus.ack, o_M0_ERR}, {(owner == 0) && s_bus.ack, (owner == 0) && to});
    check("m1_ack_err", {m1_bus.ack, o_M1_ERR}, {(owner == 1) && s_bus.ack, (owner == 1) && to});
    check("m0_rdata", m0_bus.rdata, (owner == 0) ? s_bus.rdata : '0);
    check("m1_rdata", m1_bus.rdata, (owner == 1) ? s_bus.rdata : '0);

    if (i_RST) begin
      r0    = m0_bus.cyc && !blk[0];
      r1    = m1_bus.cyc && !blk[1];
      nblk0 = m0_bus.cyc && blk[0];
      nblk1 = m1_bus.cyc && blk[1];
      if (owner < 0) begin
        if (r0 && r1)  owner = 1 - last;
        else if (r0)   owner = 0;
        else if (r1)   owner = 1;
        wait_cnt = 0;
      end else if (!cyc_of(owner)) begin
        last     = owner;
        owner    = ((owner == 0) ? r1 : r0) ? 1 - owner : -1;
        wait_cnt = 0;
      end else if (to) begin
        last = owner;
        if (owner == 0) nblk0 = 1'b1;
        else            nblk1 = 1'b1;
        owner    = -1;
        wait_cnt = 0;
      end else if (s_bus.ack) begin
        wait_cnt = 0;
      end else if (stb_of(owner)) begin
        wait_cnt++;
      end
      blk[0] = nblk0;
      blk[1] = nblk1;
    end
  end

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] sel);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.addr = addr; m0_bus.wdata = data; m0_bus.sel = sel;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.addr = addr; m1_bus.wdata = data; m1_bus.sel = sel;
    end
  endtask

  task automatic clear_inputs();
    set_m(0, 0, 0, 0, '0, '0, 4'h0);
    set_m(1, 0, 0, 0, '0, '0, 4'h0);
    s_bus.ack   = 1'b0;
    s_bus.rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_RST = 1'b0;
    step();
    step();
    i_RST = 1'b1;
  endtask

  initial begin
    int  len0, len1;
    bit  dead;

    clear_inputs();
    #1;
    check("reset_gnt", o_GNT, 2'b00);
    check("reset_err", {o_M0_ERR, o_M1_ERR}, 2'b00);
    check("reset_scyc", s_bus.cyc, 1'b0);
    step();
    i_RST = 1'b1;

    // Tie from reset goes to M0, handover without a dead cycle, round-robin afterwards.
    do_reset();
    set_m(0, 1, 1, 0, 32'h20, '0, 4'hF);
    set_m(1, 1, 1, 0, 32'h30, '0, 4'hF);
    #1 check("t2_req_cycle", o_GNT, 2'b00);
    step(); #1 check("t2_first", o_GNT, 2'b01);
    set_m(0, 0, 0, 0, 32'h20, '0, 4'hF);
    #1 check("t2_hold", o_GNT, 2'b01);
    step(); #1 check("t2_handover", o_GNT, 2'b10);
    set_m(1, 0, 0, 0, 32'h30, '0, 4'hF);
    step(); #1 check("t2_idle", o_GNT, 2'b00);
    set_m(0, 1, 1, 0, 32'h20, '0, 4'hF);
    set_m(1, 1, 1, 0, 32'h30, '0, 4'hF);
    step(); #1 check("t2_tie_m0", o_GNT, 2'b01);
    set_m(0, 0, 0, 0, 32'h20, '0, 4'hF);
    set_m(1, 0, 0, 0, 32'h30, '0, 4'hF);
    step();
    set_m(0, 1, 1, 0, 32'h20, '0, 4'hF);
    set_m(1, 1, 1, 0, 32'h30, '0, 4'hF);
    step(); #1 check("t2_tie_m1", o_GNT, 2'b10);

    // Single M0 read with the slave answering on the third granted cycle.
    do_reset();
    step();
    set_m(0, 1, 1, 0, 32'h10, '0, 4'hF);
    #1 check("t1_req_cycle", o_GNT, 2'b00);
    step(); #1 check("t1_gnt", o_GNT, 2'b01);
    check("t1_saddr", s_bus.addr, 32'h10);
    step();
    step();
    s_bus.ack   = 1'b1;
    s_bus.rdata = 32'hCAFE_0001;
    #1 check("t1_m0_ack", m0_bus.ack, 1'b1);
    check("t1_m0_data", m0_bus.rdata, 32'hCAFE_0001);
    check("t1_m1_ack", m1_bus.ack, 1'b0);
    check("t1_m1_data", m1_bus.rdata, 32'h0);
    step();
    s_bus.ack = 1'b0;
    set_m(0, 0, 0, 0, '0, '0, 4'h0);
    step(); #1 check("t1_idle", o_GNT, 2'b00);

    // M1 burst of four writes keeps the bus locked against a waiting M0.
    do_reset();
    set_m(1, 1, 0, 1, 32'h100, '0, 4'hF);
    step(); #1 check("t3_gnt_m1", o_GNT, 2'b10);
    set_m(0, 1, 1, 0, 32'h40, '0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      set_m(1, 1, 1, 1, 32'h100 + k, 32'h5500 + k, 4'hF);
      s_bus.ack = 1'b0;
      step();
      s_bus.ack = 1'b1;
      #1 check("t3_m1_ack", m1_bus.ack, 1'b1);
      check("t3_m0_ack", m0_bus.ack, 1'b0);
      check("t3_locked", o_GNT, 2'b10);
      step();
    end
    s_bus.ack = 1'b0;
    set_m(1, 0, 0, 0, '0, '0, 4'h0);
    #1 check("t3_drop_cycle", o_GNT, 2'b10);
    step(); #1 check("t3_m0_gnt", o_GNT, 2'b01);

    // Watchdog: the slave never answers M0.
    do_reset();
    set_m(0, 1, 1, 0, 32'h80, '0, 4'hF);
    step();
    for (int i = 1; i <= TO - 1; i++) begin
      #1 check("t4_no_err", o_M0_ERR, 1'b0);
      check("t4_scyc", s_bus.cyc, 1'b1);
      step();
    end
    #1 check("t4_err", o_M0_ERR, 1'b1);
    check("t4_scyc_low", {s_bus.cyc, s_bus.stb}, 2'b00);
    check("t4_no_ack", m0_bus.ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); #1 check("t4_blocked", {o_GNT, o_M0_ERR}, 3'b000);
    end
    set_m(0, 0, 0, 0, '0, '0, 4'h0);
    step();
    set_m(0, 1, 1, 0, 32'h80, '0, 4'hF);
    #1 check("t4_req_again", o_GNT, 2'b00);
    step(); #1 check("t4_regrant", o_GNT, 2'b01);

    // Reset in the middle of an M1 read.
    do_reset();
    set_m(1, 1, 1, 0, 32'h200, '0, 4'hF);
    step(); #1 check("t5_gnt_m1", o_GNT, 2'b10);
    step();
    set_m(0, 1, 1, 0, 32'h300, '0, 4'hF);
    s_bus.ack   = 1'b1;
    s_bus.rdata = 32'hDEAD_BEEF;
    i_RST       = 1'b0;
    #1 check("t5_gnt_zero", o_GNT, 2'b00);
    check("t5_sctrl_zero", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel}, 7'h00);
    check("t5_saddr_zero", s_bus.addr, 32'h0);
    check("t5_m1_zero", {m1_bus.ack, o_M1_ERR, m1_bus.rdata}, '0);
    step();
    s_bus.ack = 1'b0;
    i_RST     = 1'b1;
    #1 check("t5_after_release", o_GNT, 2'b00);
    step(); #1 check("t5_m0_first", o_GNT, 2'b01);

    // Random traffic with occasional dead-slave stretches and resets.
    do_reset();
    len0 = 0;
    len1 = 0;
    dead = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 63) == 0) dead = !dead;
      if (len0 == 0) begin
        if ($urandom_range(0, 2) == 0) len0 = $urandom_range(1, 20);
      end else begin
        len0--;
      end
      if (len1 == 0) begin
        if ($urandom_range(0, 2) == 0) len1 = $urandom_range(1, 20);
      end else begin
        len1--;
      end
      set_m(0, len0 != 0, (len0 != 0) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      set_m(1, len1 != 0, (len1 != 0) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      s_bus.ack   = !dead && ($urandom_range(0, 1) == 1);
      s_bus.rdata = $urandom;
      i_RST       = ($urandom_range(0, 699) != 0);
    end

    clear_inputs();
    i_RST = 1'b1;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
